// File: rtl/memoria_de_dados_param.sv
// Byte-addressed data memory with byte/half/word access and sign/zero-extended reads.
// Latency: writes complete at the accepting edge; read data is valid READ_LATENCY edges after acceptance.
// Backpressure: ocupado=1 while a read waits (L>1), and requests seen then are dropped silently.
//
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-low reset
//   endereco            - byte address (word index = [ADDR_WIDTH-1:2], lane = [1:0])
//   memRead, memWrite   - request strobes; both high at once is rejected
//   tamanho, semSinal   - access size (00 byte, 01 half, 10 word) and zero-extend select
//   dado_Escrito        - right-aligned write data
//   dado_Lido           - extended read data, held until the next delivery
//   dado_Valido, erro   - one-cycle pulses: read delivered / request rejected
//   ocupado             - requests are ignored this cycle
module memoria_de_dados_param #(
  parameter int MEM_SIZE     = 150,
  parameter int ADDR_WIDTH   = 26,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] endereco,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            tamanho,
  input  logic                  semSinal,
  input  logic [31:0]           dado_Escrito,
  output logic [31:0]           dado_Lido,
  output logic                  dado_Valido,
  output logic                  ocupado,
  output logic                  erro
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MIDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  // Extra ESPERA cycles after the first one; only meaningful when READ_LATENCY > 1.
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 2);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    ENTREGA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] lido_q, lido_d;
  logic        erro_q, erro_d;

  logic [31:0] mem_q [MEM_SIZE];

  logic [IDX_W-1:0]  word_idx;
  logic [MIDX_W-1:0] mem_idx;
  logic [1:0]        lane;
  logic              in_range;
  logic              bad_req;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_dat;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       rd_fmt;

  assign word_idx = endereco[ADDR_WIDTH-1:2];
  assign mem_idx  = word_idx[MIDX_W-1:0];
  assign lane     = endereco[1:0];
  assign in_range = (32'(word_idx) < MEM_SIZE);

  // Rejection covers malformed requests only; ignoring during ESPERA is handled by the FSM.
  always_comb begin
    bad_req = (memRead & memWrite) | ~in_range;
    case (tamanho)
      2'b00:   bad_req = bad_req;
      2'b01:   bad_req = bad_req | lane[0];
      2'b10:   bad_req = bad_req | (lane != 2'b00);
      default: bad_req = 1'b1;
    endcase
  end

  // Read path: pick lane(s), shift to bit 0, then extend.
  always_comb begin
    rd_word = mem_q[mem_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (tamanho)
      2'b00:   rd_fmt = semSinal ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_fmt = semSinal ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_fmt = rd_word;
    endcase
  end

  // Write path: replicate the data across lanes and let the byte enables pick the targets.
  always_comb begin
    wr_be  = 4'b1111;
    wr_dat = dado_Escrito;
    case (tamanho)
      2'b00: begin
        wr_be  = 4'b0001 << lane;
        wr_dat = {4{dado_Escrito[7:0]}};
      end
      2'b01: begin
        wr_be  = lane[1] ? 4'b1100 : 4'b0011;
        wr_dat = {2{dado_Escrito[15:0]}};
      end
      default: begin
        wr_be  = 4'b1111;
        wr_dat = dado_Escrito;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    lido_d  = lido_q;
    erro_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ESPERA: begin
        if (cnt_q == 2'd0) begin
          state_d = ENTREGA;
          lido_d  = pend_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        // OCIOSO and ENTREGA both accept; ENTREGA lasts one cycle, so L=1 streams reads.
        state_d = OCIOSO;
        if (memRead | memWrite) begin
          if (bad_req) begin
            erro_d = 1'b1;
          end else if (memWrite) begin
            wr_en = 1'b1;
          end else if (READ_LATENCY == 1) begin
            state_d = ENTREGA;
            lido_d  = rd_fmt;
          end else begin
            // Result is captured now so a later write cannot change what gets delivered.
            state_d = ESPERA;
            pend_d  = rd_fmt;
            cnt_d   = CNT_INIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= OCIOSO;
      cnt_q   <= 2'd0;
      pend_q  <= 32'h0;
      lido_q  <= 32'h0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      lido_q  <= lido_d;
      erro_q  <= erro_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[mem_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  assign dado_Lido   = lido_q;
  assign dado_Valido = (state_q == ENTREGA);
  assign ocupado     = (state_q == ESPERA);
  assign erro        = erro_q;

endmodule

// File: tb/tb_memoria_de_dados_param.sv
module tb_memoria_de_dados_param;

  logic        clk;
  logic        rst_n;
  logic [25:0] addr;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sem;
  logic [31:0] wdat;
  logic [2:0]  sel;

  logic [31:0] lido1, lido3, lido4;
  logic        vld1, vld3, vld4;
  logic        oc1, oc3, oc4;
  logic        er1, er3, er4;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  memoria_de_dados_param #(.MEM_SIZE(150), .ADDR_WIDTH(26), .READ_LATENCY(1)) u_dut1 (
    .clock(clk), .reset(rst_n), .endereco(addr),
    .memRead(mem_read & sel[0]), .memWrite(mem_write & sel[0]),
    .tamanho(size), .semSinal(sem), .dado_Escrito(wdat),
    .dado_Lido(lido1), .dado_Valido(vld1), .ocupado(oc1), .erro(er1));

  memoria_de_dados_param #(.MEM_SIZE(150), .ADDR_WIDTH(26), .READ_LATENCY(3)) u_dut3 (
    .clock(clk), .reset(rst_n), .endereco(addr),
    .memRead(mem_read & sel[1]), .memWrite(mem_write & sel[1]),
    .tamanho(size), .semSinal(sem), .dado_Escrito(wdat),
    .dado_Lido(lido3), .dado_Valido(vld3), .ocupado(oc3), .erro(er3));

  memoria_de_dados_param #(.MEM_SIZE(150), .ADDR_WIDTH(26), .READ_LATENCY(4)) u_dut4 (
    .clock(clk), .reset(rst_n), .endereco(addr),
    .memRead(mem_read & sel[2]), .memWrite(mem_write & sel[2]),
    .tamanho(size), .semSinal(sem), .dado_Escrito(wdat),
    .dado_Lido(lido4), .dado_Valido(vld4), .ocupado(oc4), .erro(er4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sm;
    logic [25:0] a;
    logic [31:0] d;
    logic        ev;
    logic        ee;
    logic [31:0] el;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sm, input logic [25:0] a, input logic [31:0] d,
                              input logic ev, input logic ee, input logic [31:0] el);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.sm = sm; v.a = a; v.d = d;
    v.ev = ev; v.ee = ee; v.el = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sm, input logic [25:0] a, input logic [31:0] d);
    mem_read = rd; mem_write = wr; size = sz; sem = sm; addr = a; wdat = d;
  endtask

  task automatic idle();
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Advance through one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[24];

  initial begin
    vecs[0]  = mk(0, 1, SW, 0, 26'h10,  32'hDEADBEEF, 0, 0, 32'h00000000);
    vecs[1]  = mk(1, 0, SW, 0, 26'h10,  32'h0,        1, 0, 32'hDEADBEEF);
    vecs[2]  = mk(0, 0, SW, 0, 26'h10,  32'h0,        0, 0, 32'hDEADBEEF);
    vecs[3]  = mk(0, 1, SB, 0, 26'h11,  32'h12345680, 0, 0, 32'hDEADBEEF);
    vecs[4]  = mk(1, 0, SB, 0, 26'h11,  32'h0,        1, 0, 32'hFFFFFF80);
    vecs[5]  = mk(1, 0, SB, 1, 26'h11,  32'h0,        1, 0, 32'h00000080);
    vecs[6]  = mk(1, 0, SH, 0, 26'h12,  32'h0,        1, 0, 32'hFFFFDEAD);
    vecs[7]  = mk(1, 0, SH, 1, 26'h12,  32'h0,        1, 0, 32'h0000DEAD);
    vecs[8]  = mk(1, 0, SW, 1, 26'h10,  32'h0,        1, 0, 32'hDEAD80EF);
    vecs[9]  = mk(1, 0, SB, 0, 26'h10,  32'h0,        1, 0, 32'hFFFFFFEF);
    vecs[10] = mk(0, 1, SH, 0, 26'h12,  32'hAAAA1234, 0, 0, 32'hFFFFFFEF);
    vecs[11] = mk(1, 0, SW, 0, 26'h10,  32'h0,        1, 0, 32'h123480EF);
    vecs[12] = mk(0, 1, SW, 0, 26'h10,  32'h11112222, 0, 0, 32'h123480EF);
    vecs[13] = mk(1, 0, SW, 0, 26'h10,  32'h0,        1, 0, 32'h11112222);
    vecs[14] = mk(1, 0, SW, 0, 26'h13,  32'h0,        0, 1, 32'h11112222);
    vecs[15] = mk(0, 1, SH, 0, 26'h11,  32'h0000FFFF, 0, 1, 32'h11112222);
    vecs[16] = mk(1, 0, SX, 0, 26'h10,  32'h0,        0, 1, 32'h11112222);
    vecs[17] = mk(1, 0, SW, 0, 26'h258, 32'h0,        0, 1, 32'h11112222);
    vecs[18] = mk(1, 1, SW, 0, 26'h10,  32'h0,        0, 1, 32'h11112222);
    vecs[19] = mk(0, 1, SW, 0, 26'h254, 32'hCAFEF00D, 0, 0, 32'h11112222);
    vecs[20] = mk(1, 0, SW, 0, 26'h254, 32'h0,        1, 0, 32'hCAFEF00D);
    vecs[21] = mk(1, 0, SW, 0, 26'h10,  32'h0,        1, 0, 32'h11112222);
    vecs[22] = mk(1, 0, SB, 0, 26'h13,  32'h0,        1, 0, 32'h00000011);
    vecs[23] = mk(1, 0, SH, 0, 26'h10,  32'h0,        1, 0, 32'h00002222);

    rst_n = 1'b0;
    sel   = 3'b000;
    drive(0, 0, SW, 0, 26'h0, 32'h0);
    #12;
    chk("rst lido1", lido1, 32'h0);  chk("rst vld1", 32'(vld1), 32'h0);
    chk("rst oc1", 32'(oc1), 32'h0); chk("rst er1", 32'(er1), 32'h0);
    chk("rst lido4", lido4, 32'h0);  chk("rst vld4", 32'(vld4), 32'h0);
    chk("rst oc4", 32'(oc4), 32'h0); chk("rst er4", 32'(er4), 32'h0);
    #1 rst_n = 1'b1;

    // L=1 table
    sel = 3'b001;
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].sm, vecs[i].a, vecs[i].d);
      cyc();
      chk($sformatf("v%0d vld", i),  32'(vld1), 32'(vecs[i].ev));
      chk($sformatf("v%0d erro", i), 32'(er1),  32'(vecs[i].ee));
      chk($sformatf("v%0d lido", i), lido1,     vecs[i].el);
      chk($sformatf("v%0d oc", i),   32'(oc1),  32'h0);
    end
    idle();
    cyc();
    chk("v end erro clear", 32'(er1), 32'h0);

    // L=3: two ESPERA cycles, write during ESPERA dropped
    sel = 3'b010;
    drive(0, 1, SW, 0, 26'h10, 32'hDEADBEEF);
    cyc();
    chk("l3 wr oc", 32'(oc3), 32'h0);
    drive(1, 0, SW, 0, 26'h10, 32'h0);
    cyc();
    chk("l3 k oc", 32'(oc3), 32'h1);
    chk("l3 k vld", 32'(vld3), 32'h0);
    drive(0, 1, SW, 0, 26'h10, 32'h00000000);
    cyc();
    chk("l3 k1 oc", 32'(oc3), 32'h1);
    chk("l3 k1 vld", 32'(vld3), 32'h0);
    chk("l3 k1 erro", 32'(er3), 32'h0);
    cyc();
    idle();
    chk("l3 k2 oc", 32'(oc3), 32'h0);
    chk("l3 k2 vld", 32'(vld3), 32'h1);
    chk("l3 k2 lido", lido3, 32'hDEADBEEF);
    chk("l3 k2 erro", 32'(er3), 32'h0);
    cyc();
    chk("l3 k3 vld", 32'(vld3), 32'h0);
    drive(1, 0, SW, 0, 26'h10, 32'h0);
    cyc();
    idle();
    cyc();
    cyc();
    chk("l3 rb vld", 32'(vld3), 32'h1);
    chk("l3 rb lido", lido3, 32'hDEADBEEF);

    // L=4: reset in ESPERA abandons the read, memory survives
    sel = 3'b100;
    drive(0, 1, SW, 0, 26'h10, 32'h0BADCAFE);
    cyc();
    drive(1, 0, SW, 0, 26'h10, 32'h0);
    cyc();
    idle();
    cyc();
    cyc();
    cyc();
    chk("l4 first vld", 32'(vld4), 32'h1);
    chk("l4 first lido", lido4, 32'h0BADCAFE);
    drive(1, 0, SW, 0, 26'h10, 32'h0);
    cyc();
    idle();
    chk("l4 pend oc", 32'(oc4), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("l4 rst lido", lido4, 32'h0);
    chk("l4 rst vld", 32'(vld4), 32'h0);
    chk("l4 rst oc", 32'(oc4), 32'h0);
    chk("l4 rst erro", 32'(er4), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(1, 0, SW, 0, 26'h10, 32'h0);
    cyc();
    idle();
    chk("l4 post acc oc", 32'(oc4), 32'h1);
    for (int j = 0; j < 2; j++) begin
      cyc();
      chk($sformatf("l4 post wait%0d vld", j), 32'(vld4), 32'h0);
      chk($sformatf("l4 post wait%0d oc", j), 32'(oc4), 32'h1);
    end
    cyc();
    chk("l4 post vld", 32'(vld4), 32'h1);
    chk("l4 post lido", lido4, 32'h0BADCAFE);
    for (int j = 0; j < 4; j++) begin
      cyc();
      chk($sformatf("l4 quiet%0d vld", j), 32'(vld4), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
